// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_port_arbiter
//  Purpose  : Round-robin sharing of the single-port rom_C and rom_read_and_D
//             lookup ROMs between parallel get-data lanes. One lane is granted
//             per cycle; responses return tagged with the lane id, in grant
//             order, ROM_LAT+2 cycles after the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int ROM_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_need_c,
   input  logic [NUM_REQ-1:0]     req_need_d,
   input  logic [2*NUM_REQ-1:0]   req_addr_c,
   input  logic [8*NUM_REQ-1:0]   req_addr_d,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   ce_rom_C,
   output logic [1:0]             addr_rom_C,
   output logic                   ce_rom_read_and_D,
   output logic [7:0]             addr_rom_read_and_D,
   input  logic [7:0]             data,
   input  logic [7:0]             d_i,
   input  logic [1:0]             read_i,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [7:0]             rsp_C,
   output logic [7:0]             rsp_d_i,
   output logic [1:0]             rsp_read_i,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t                     state;
   logic [ID_W-1:0]            ptr;        // last granted lane
   logic                       found;
   logic [ID_W-1:0]            gidx;
   logic [ID_W-1:0]            cand;
   logic                       grant;
   logic                       sel_need_c;
   logic                       sel_need_d;
   logic [1:0]                 sel_addr_c;
   logic [7:0]                 sel_addr_d;
   logic                       in_flight;

   // Stage 0 is the issue stage (ROM address cycle); stage ROM_LAT lines up
   // with the ROM read data.
   logic [ROM_LAT:0]           tag_v;
   logic [ROM_LAT:0][ID_W-1:0] tag_id;
   logic [ROM_LAT:0]           tag_nc;
   logic [ROM_LAT:0]           tag_nd;

   // Round-robin search: first valid lane strictly after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gidx  = cand;
         end
      end
   end

   // Grant is suppressed while enable is low or reset is held.
   assign grant      = en & found & ~rst;
   assign sel_need_c = req_need_c[gidx];
   assign sel_need_d = req_need_d[gidx];
   assign sel_addr_c = req_addr_c[{gidx, 1'b0} +: 2];
   assign sel_addr_d = req_addr_d[{gidx, 3'b000} +: 8];
   assign in_flight  = |tag_v;

   // One-hot ready for the winning lane.
   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[gidx] = 1'b1;
      end
   end

   // Issue register drives the ROMs; the tag pipeline tracks ROM latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_rom_C            <= 1'b0;
         addr_rom_C          <= 2'b00;
         ce_rom_read_and_D   <= 1'b0;
         addr_rom_read_and_D <= 8'h00;
         tag_v               <= '0;
         tag_id              <= '0;
         tag_nc              <= '0;
         tag_nd              <= '0;
      end else begin
         ce_rom_C            <= grant & sel_need_c;
         addr_rom_C          <= (grant & sel_need_c) ? sel_addr_c : 2'b00;
         ce_rom_read_and_D   <= grant & sel_need_d;
         addr_rom_read_and_D <= (grant & sel_need_d) ? sel_addr_d : 8'h00;
         tag_v[0]            <= grant;
         tag_id[0]           <= gidx;
         tag_nc[0]           <= grant & sel_need_c;
         tag_nd[0]           <= grant & sel_need_d;
         for (int k = 1; k <= ROM_LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
            tag_nc[k] <= tag_nc[k-1];
            tag_nd[k] <= tag_nd[k-1];
         end
      end
   end

   // Response capture; unrequested fields are zeroed, values hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_C      <= 8'h00;
         rsp_d_i    <= 8'h00;
         rsp_read_i <= 2'b00;
      end else begin
         rsp_valid <= tag_v[ROM_LAT];
         if (tag_v[ROM_LAT]) begin
            rsp_id     <= tag_id[ROM_LAT];
            rsp_C      <= tag_nc[ROM_LAT] ? data   : 8'h00;
            rsp_d_i    <= tag_nd[ROM_LAT] ? d_i    : 8'h00;
            rsp_read_i <= tag_nd[ROM_LAT] ? read_i : 2'b00;
         end
      end
   end

   // Control state and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         ptr   <= ID_W'(NUM_REQ - 1);
      end else begin
         if (grant) begin
            ptr <= gidx;
         end
         case (state)
            ST_IDLE: begin
               if (en && (|req_valid)) state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (!en && in_flight)          state <= ST_DRAIN;
               else if (!in_flight && !grant) state <= ST_IDLE;
            end
            ST_DRAIN: begin
               if (en)              state <= ST_ACTIVE;
               else if (!in_flight) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (|req_ready) | in_flight | rsp_valid;

endmodule
`default_nettype wire
